// File: rtl/hrm_mailbox.sv
// -----------------------------------------------------------------------------
// hrm_mailbox
//   Parametrised INBOX/OUTBOX queue for the HRM CPU. Circular buffer of
//   DEPTH = 2**LGFLEN words of DW bits, with an occupancy counter, threshold
//   flags, sticky overflow/underflow flags, a synchronous clear from the
//   control unit and a combinational dump port for the debug display.
//
// Ports
//   clk            system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_clr          synchronous clear, same effect as reset except storage
//   i_wr, i_data   push request and data
//   i_rd           pop request
//   o_data         head word (FWFT=1) or last popped word (FWFT=0)
//   o_empty_n      queue not empty
//   o_full         level == DEPTH
//   o_level        occupancy 0..DEPTH
//   o_almost_full  level >= AF_THRESH
//   o_almost_empty level <= AE_THRESH
//   o_ovf, o_udf   sticky rejected-push / rejected-pop flags
//   i_dmp_pos      dump offset from head
//   o_dmp_data     entry at head + i_dmp_pos (0 when not valid)
//   o_dmp_valid    i_dmp_pos < level
// -----------------------------------------------------------------------------
module hrm_mailbox #(
    parameter int DW        = 8,
    parameter int LGFLEN    = 5,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = (1 << LGFLEN) - 4,
    parameter int AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_wr,
    input  logic [DW-1:0]     i_data,
    input  logic              i_rd,
    output logic [DW-1:0]     o_data,
    output logic              o_empty_n,
    output logic              o_full,
    output logic [LGFLEN:0]   o_level,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic              o_ovf,
    output logic              o_udf,
    input  logic [LGFLEN-1:0] i_dmp_pos,
    output logic [DW-1:0]     o_dmp_data,
    output logic              o_dmp_valid
);

    localparam int              DEPTH   = 1 << LGFLEN;
    localparam logic [LGFLEN:0] DEPTH_L = (LGFLEN + 1)'(DEPTH);
    localparam logic [LGFLEN:0] AF_L    = (LGFLEN + 1)'(AF_THRESH);
    localparam logic [LGFLEN:0] AE_L    = (LGFLEN + 1)'(AE_THRESH);

    logic [DW-1:0]     mem_q [DEPTH];
    logic              mem_we;

    logic [LGFLEN-1:0] rptr_q,  rptr_d;
    logic [LGFLEN-1:0] wptr_q,  wptr_d;
    logic [LGFLEN:0]   level_q, level_d;
    logic              ovf_q,   ovf_d;
    logic              udf_q,   udf_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic              rd_ok;
    logic              wr_ok;
    logic [LGFLEN-1:0] dmp_idx;

    // Next-state logic. A full queue still accepts a push when a pop is
    // accepted in the same cycle, because the popped slot is the one written.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        rd_ok   = i_rd && (level_q != '0);
        wr_ok   = i_wr && ((level_q != DEPTH_L) || rd_ok);
        mem_we  = 1'b0;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        rdata_d = rdata_q;

        if (i_clr) begin
            // Clear wins over any push/pop in the same cycle; flags are not updated.
            rptr_d  = '0;
            wptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            rdata_d = '0;
        end else begin
            mem_we = wr_ok;
            if (rd_ok) begin
                rptr_d  = rptr_q + LGFLEN'(1);
                rdata_d = mem_q[rptr_q];
            end
            if (wr_ok) begin
                wptr_d = wptr_q + LGFLEN'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level_d = level_q + (LGFLEN + 1)'(1);
                2'b01:   level_d = level_q - (LGFLEN + 1)'(1);
                default: level_d = level_q;
            endcase
            ovf_d = ovf_q | (i_wr & ~wr_ok);
            udf_d = udf_q | (i_rd & ~rd_ok);
        end
    end

    // NOTE: storage is deliberately left out of reset; only valid entries are ever observable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wptr_q] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            rdata_q <= rdata_d;
        end
    end

    // Status depends only on the registered level, never on same-cycle requests.
    assign o_level        = level_q;
    assign o_empty_n      = (level_q != '0);
    assign o_full         = (level_q == DEPTH_L);
    assign o_almost_full  = (level_q >= AF_L);
    assign o_almost_empty = (level_q <= AE_L);
    assign o_ovf          = ovf_q;
    assign o_udf          = udf_q;

    // Fall-through mode shows the head directly; registered mode shows the
    // word captured by the last accepted pop.
    assign o_data = (FWFT != 0) ? (o_empty_n ? mem_q[rptr_q] : '0) : rdata_q;

    // Dump index wraps naturally in LGFLEN bits.
    assign dmp_idx     = rptr_q + i_dmp_pos;
    assign o_dmp_valid = ({1'b0, i_dmp_pos} < level_q);
    assign o_dmp_data  = o_dmp_valid ? mem_q[dmp_idx] : '0;

endmodule

// File: tb/tb_hrm_mailbox.sv
// -----------------------------------------------------------------------------
// tb_hrm_mailbox
//   Drives one fall-through and one registered-read mailbox with identical
//   stimulus and compares both against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_hrm_mailbox;

    localparam int DEPTH = 32;

    logic       clk;
    logic       i_rst, i_clr, i_wr, i_rd;
    logic [7:0] i_data;
    logic [4:0] i_dmp_pos;

    logic [7:0] o_data,   o_data_r;
    logic       o_empty_n, o_empty_n_r;
    logic       o_full,   o_full_r;
    logic [5:0] o_level,  o_level_r;
    logic       o_af,     o_af_r;
    logic       o_ae,     o_ae_r;
    logic       o_ovf,    o_ovf_r;
    logic       o_udf,    o_udf_r;
    logic [7:0] o_dmp_data, o_dmp_data_r;
    logic       o_dmp_valid, o_dmp_valid_r;

    hrm_mailbox #(.DW(8), .LGFLEN(5), .FWFT(1)) dut (
        .clk(clk), .i_rst(i_rst), .i_clr(i_clr), .i_wr(i_wr), .i_data(i_data),
        .i_rd(i_rd), .o_data(o_data), .o_empty_n(o_empty_n), .o_full(o_full),
        .o_level(o_level), .o_almost_full(o_af), .o_almost_empty(o_ae),
        .o_ovf(o_ovf), .o_udf(o_udf), .i_dmp_pos(i_dmp_pos),
        .o_dmp_data(o_dmp_data), .o_dmp_valid(o_dmp_valid)
    );

    hrm_mailbox #(.DW(8), .LGFLEN(5), .FWFT(0)) dut_reg (
        .clk(clk), .i_rst(i_rst), .i_clr(i_clr), .i_wr(i_wr), .i_data(i_data),
        .i_rd(i_rd), .o_data(o_data_r), .o_empty_n(o_empty_n_r), .o_full(o_full_r),
        .o_level(o_level_r), .o_almost_full(o_af_r), .o_almost_empty(o_ae_r),
        .o_ovf(o_ovf_r), .o_udf(o_udf_r), .i_dmp_pos(i_dmp_pos),
        .o_dmp_data(o_dmp_data_r), .o_dmp_valid(o_dmp_valid_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the queue contents themselves, plus flags and the last popped word.
    bit [7:0] mq[$];
    bit       m_ovf, m_udf;
    bit [7:0] m_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_last = 8'h00;
    endtask

    task automatic model_step(input bit wr, input bit [7:0] d, input bit rd, input bit clr);
        bit rok, wok;
        if (clr) begin
            model_reset();
            return;
        end
        rok = rd && (mq.size() != 0);
        wok = wr && ((mq.size() != DEPTH) || rok);
        if (rok) m_last = mq.pop_front();
        if (wok) mq.push_back(d);
        if (wr && !wok) m_ovf = 1'b1;
        if (rd && !rok) m_udf = 1'b1;
    endtask

    task automatic check_all();
        int n, p;
        n = mq.size();
        p = int'(i_dmp_pos);
        check("level",     o_level,     n);
        check("empty_n",   o_empty_n,   n != 0);
        check("full",      o_full,      n == DEPTH);
        check("afull",     o_af,        n >= DEPTH - 4);
        check("aempty",    o_ae,        n <= 1);
        check("ovf",       o_ovf,       m_ovf);
        check("udf",       o_udf,       m_udf);
        check("data_fwft", o_data,      (n != 0) ? mq[0] : 8'h00);
        check("dmp_valid", o_dmp_valid, p < n);
        check("dmp_data",  o_dmp_data,  (p < n) ? mq[p] : 8'h00);
        check("level_r",   o_level_r,   n);
        check("ovf_r",     o_ovf_r,     m_ovf);
        check("udf_r",     o_udf_r,     m_udf);
        check("data_reg",  o_data_r,    m_last);
    endtask

    // One clock: drive inputs, let the edge happen, update the model, sample 1 time unit later.
    task automatic cycle(input bit wr, input bit [7:0] d, input bit rd, input bit clr, input int dmp);
        i_wr      = wr;
        i_data    = d;
        i_rd      = rd;
        i_clr     = clr;
        i_dmp_pos = 5'(dmp);
        @(posedge clk);
        model_step(wr, d, rd, clr);
        #1;
        check_all();
    endtask

    // Assert reset between edges and check outputs before the next edge arrives.
    task automatic async_reset();
        i_wr  = 1'b0;
        i_rd  = 1'b0;
        i_clr = 1'b0;
        @(posedge clk);
        #2;
        i_rst = 1'b1;
        #2;
        model_reset();
        check("arst_level",   o_level,   0);
        check("arst_empty_n", o_empty_n, 0);
        check("arst_aempty",  o_ae,      1);
        check("arst_data_r",  o_data_r,  0);
        check_all();
        #2;
        i_rst = 1'b0;
    endtask

    function automatic int rpos();
        return int'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        i_rst = 1'b1; i_clr = 1'b0; i_wr = 1'b0; i_rd = 1'b0;
        i_data = 8'h00; i_dmp_pos = 5'd0;
        model_reset();
        #2;
        check("rst_empty_n", o_empty_n, 0);
        check("rst_full",    o_full,    0);
        check("rst_aempty",  o_ae,      1);
        check("rst_afull",   o_af,      0);
        check_all();
        #6;
        i_rst = 1'b0;

        // Fill to full with 0x01..0x20, then one rejected push.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, rpos());
        check("full_after32", o_full,  1);
        check("level32",      o_level, 32);
        cycle(1'b1, 8'h55, 1'b0, 1'b0, 0);
        check("ovf_on_33rd",  o_ovf,   1);
        check("level_still32", o_level, 32);

        // Push and pop together while full.
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 31);
        check("full_pp_level", o_level,    32);
        check("full_pp_pop",   o_data_r,   8'h01);
        check("full_pp_head",  o_data,     8'h02);
        check("full_pp_dmp31", o_dmp_data, 8'h77);

        // Underflow on empty, then push+pop on empty.
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
        check("udf_set",    o_udf,  1);
        check("udf_data",   o_data, 8'h00);
        cycle(1'b1, 8'h10, 1'b1, 1'b0, 0);
        check("pp_empty_level", o_level, 1);
        check("pp_empty_data",  o_data,  8'h10);

        // Wrap: move pointers to 20, then push 16 words across the end.
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, rpos());
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, rpos());
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, rpos());
        for (int i = 0; i <= 16; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, i);
        check("wrap_pos16_valid", o_dmp_valid, 0);
        check("wrap_pos16_data",  o_dmp_data,  8'h00);

        // Registered-read latency.
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 0);
        cycle(1'b1, 8'h4D, 1'b0, 1'b0, 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
        check("reg_first",  o_data_r, 8'h3C);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
        check("reg_second", o_data_r, 8'h4D);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 0);
        check("reg_hold",   o_data_r, 8'h4D);

        // Clear priority with 5 entries and both flags set.
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
        for (int i = 0; i <= DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, rpos());
        for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, rpos());
        check("pre_clr_level", o_level, 5);
        check("pre_clr_ovf",   o_ovf,   1);
        check("pre_clr_udf",   o_udf,   1);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1, 0);
        check("clr_level", o_level, 0);
        check("clr_ovf",   o_ovf,   0);
        check("clr_udf",   o_udf,   0);

        // Asynchronous reset in the middle of a partially filled queue.
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, rpos());
        cycle(1'b1, 8'h12, 1'b0, 1'b0, 0);
        async_reset();

        // Randomised traffic with drifting fill/drain bias.
        for (int blk = 0; blk < 20; blk++) begin
            int wp, rp;
            case (blk % 3)
                0:       begin wp = 85; rp = 25; end
                1:       begin wp = 25; rp = 85; end
                default: begin wp = 55; rp = 55; end
            endcase
            for (int i = 0; i < 150; i++) begin
                cycle($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
                      $urandom_range(0, 199) == 0, rpos());
            end
            if (blk % 7 == 6) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hrm_mailbox.md
Name: hrm_mailbox

Overview:
- Parametrised INBOX/OUTBOX queue for the HRM CPU; successor to the fixed 8-bit, 32-entry mailbox FIFO.
- Adds:
  - configurable data width and depth
  - a fall-through or registered read mode
  - occupancy level output and almost-full/almost-empty thresholds
  - sticky overflow/underflow flags
  - a synchronous clear driven by the control unit
- Keeps the combinational dump port used by the debug display.

Parameters:
- DW, 8: data width in bits.
- LGFLEN, 5: log2 of depth; DEPTH = 2^LGFLEN entries.
- FWFT, 1: 1 = first-word-fall-through read; 0 = registered read, 1-cycle latency.
- AF_THRESH, DEPTH-4: o_almost_full asserts when level >= AF_THRESH.
- AE_THRESH, 1: o_almost_empty asserts when level <= AE_THRESH.

Ports:
- clk  input  1  system clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_clr  input  1  synchronous clear (CPU reset from control unit).
- i_wr  input  1  push request.
- i_data  input  DW  push data.
- i_rd  input  1  pop request.
- o_data  output  DW  head data (FWFT=1) or last popped data (FWFT=0).
- o_empty_n  output  1  queue not empty.
- o_full  output  1  level == DEPTH.
- o_level  output  LGFLEN+1  current occupancy, 0..DEPTH.
- o_almost_full  output  1  level >= AF_THRESH.
- o_almost_empty  output  1  level <= AE_THRESH.
- o_ovf  output  1  sticky: a push was rejected.
- o_udf  output  1  sticky: a pop was rejected.
- i_dmp_pos  input  LGFLEN  dump offset from head (0 = head).
- o_dmp_data  output  DW  entry at head+i_dmp_pos.
- o_dmp_valid  output  1  i_dmp_pos < level.

Behaviour:
- State: storage array (DEPTH x DW), rptr/wptr (LGFLEN bits, natural wrap modulo DEPTH), level counter, sticky flags, o_data register (FWFT=0 only).
- Reset (i_rst high, asynchronous): pointers 0, level 0, o_ovf/o_udf 0, o_data register 0. Outputs immediately become o_empty_n=0, o_full=0, o_almost_empty=1, o_almost_full=(AF_THRESH==0). Storage contents are not reset.
- i_clr high at a clock edge has the same effect as reset on all state except storage. It has priority over i_wr/i_rd in that cycle; both are ignored with no flag update.
- Pop acceptance: rd_ok = i_rd && level != 0. Accepted pop advances rptr.
- Push acceptance: wr_ok = i_wr && (level != DEPTH || rd_ok). Accepted push writes storage[wptr] = i_data and advances wptr.
- Level update: level += wr_ok - rd_ok.
  - Simultaneous push+pop when full: both accepted, level stays DEPTH, o_full stays 1.
  - Simultaneous push+pop when empty: push accepted, pop rejected (sets o_udf), level becomes 1.
- o_ovf sets on i_wr && !wr_ok. o_udf sets on i_rd && !rd_ok. Both hold until i_rst or i_clr.
- Status outputs are combinational from the registered level only (no dependence on same-cycle i_wr/i_rd): o_empty_n=(level!=0), o_full=(level==DEPTH), o_almost_full, o_almost_empty.
- FWFT=1: o_data = storage[rptr] when level != 0, else 0. A new head is visible the cycle after the push that filled the empty queue.
- FWFT=0: on rd_ok, the o_data register loads storage[rptr] at that edge; value visible 1 cycle after the pop request. Otherwise it holds. A rejected pop leaves o_data unchanged.
- Dump port (combinational):
  - o_dmp_data = storage[(rptr + i_dmp_pos) mod DEPTH] when o_dmp_valid, else 0.
  - o_dmp_valid = (i_dmp_pos < level).
  - The dump port has no effect on state.
- Arithmetic: pointer increments and the dump index wrap modulo DEPTH. o_level is LGFLEN+1 bits so DEPTH is representable.
- Reset mid-operation: any in-flight push/pop at the asserting edge is discarded; behaviour restarts from empty.

Test Plan:
- DW=8, LGFLEN=5, FWFT=1: push 0x01..0x20 (32 words) → o_full=1 after the 32nd, o_level=32, o_almost_full from level 28. 33rd push 0x55 → rejected, o_ovf=1, o_level=32.
- Full queue, push 0x77 and pop in the same cycle → o_level stays 32, popped 0x01, next head o_data=0x02, 0x77 at dump pos 31.
- Empty queue, pop → o_udf=1, o_level=0, o_data=0. Then push 0x10 and pop in the same cycle → o_level=1, o_data=0x10.
- Wrap: push 20, pop 20, push 0xA0..0xAF (16 words) → dump pos 0..15 = 0xA0..0xAF with o_dmp_valid=1; pos 16 → o_dmp_valid=0, o_dmp_data=0.
- FWFT=0: push 0x3C, 0x4D, then pop twice on consecutive cycles → o_data=0x3C one cycle after the first pop, 0x4D after the second, held afterward.
- With 5 entries and o_ovf/o_udf set: assert i_clr together with i_wr → o_level=0, flags cleared, push ignored. Assert i_rst asynchronously between edges → outputs go to reset values before the next clk edge.
